mem_stage_ctrl: RTL and testbench

//  Memory-stage access controller of the pipelined RISC-V core. It is the producer side of the MEM/WB register.
//  - Takes the EX/MEM load/store request and runs a req/ack handshake to data memory.
//  - Formats load data into memres_out and stalls the pipeline while an access is outstanding.
//  - Drives wb_we, which is the write enable of the MEM/WB register.

---
 rtl/mem_stage_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: memory-stage load/store controller, req/ack master to data memory and MEM/WB enable source.
// Optional feature macro MISALIGN_TRAP_EN: misaligned half/word accesses skip the bus and pulse misalign.
module mem_stage_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output logic        wb_we,
  output logic [31:0] memres_out,
  output logic        bus_err,
  output logic        misalign
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [7:0] COUNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [7:0]  count_q, count_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] memres_q, memres_d;
  logic        bus_err_q, bus_err_d;

  logic        access;
  logic [1:0]  lane;
  logic [1:0]  size_lat;
  logic [3:0]  be_lat;
  logic [31:0] wdata_rep;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_fmt;
  logic        stall_c;

  // Stores only know SB/SH; loads also treat funct3 4/5 as byte/half (unsigned forms).
  function automatic logic [1:0] access_size(input logic we, input logic [2:0] f3);
    logic [1:0] sz;
    if (we) begin
      if (f3 == 3'd0)      sz = SZ_BYTE;
      else if (f3 == 3'd1) sz = SZ_HALF;
      else                 sz = SZ_WORD;
    end else begin
      case (f3[1:0])
        2'd0:    sz = SZ_BYTE;
        2'd1:    sz = SZ_HALF;
        default: sz = SZ_WORD;
      endcase
    end
    return sz;
  endfunction

`ifdef MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;
  logic req_misaligned;

  always_comb begin
    case (access_size(req_we, req_funct3))
      SZ_HALF: req_misaligned = req_addr[0];
      SZ_WORD: req_misaligned = |req_addr[1:0];
      default: req_misaligned = 1'b0;
    endcase
  end
`endif

  // Store lane steering from the latched request
  always_comb begin
    lane      = addr_q[1:0];
    size_lat  = access_size(we_q, funct3_q);
    be_lat    = 4'b1111;
    wdata_rep = wdata_q;
    if (we_q) begin
      case (size_lat)
        SZ_BYTE: begin
          be_lat    = 4'b0001 << lane;
          wdata_rep = {4{wdata_q[7:0]}};
        end
        SZ_HALF: begin
          be_lat    = 4'b0011 << {lane[1], 1'b0};
          wdata_rep = {2{wdata_q[15:0]}};
        end
        default: ;
      endcase
    end
  end

  // Load result formatting
  always_comb begin
    case (lane)
      2'd0:    rd_byte = dmem_rdata[7:0];
      2'd1:    rd_byte = dmem_rdata[15:8];
      2'd2:    rd_byte = dmem_rdata[23:16];
      default: rd_byte = dmem_rdata[31:24];
    endcase
    rd_half = lane[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (funct3_q)
      3'd0:    load_fmt = {{24{rd_byte[7]}}, rd_byte};
      3'd4:    load_fmt = {24'b0, rd_byte};
      3'd1:    load_fmt = {{16{rd_half[15]}}, rd_half};
      3'd5:    load_fmt = {16'b0, rd_half};
      default: load_fmt = dmem_rdata;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    addr_d    = addr_q;
    we_d      = we_q;
    funct3_d  = funct3_q;
    wdata_d   = wdata_q;
    memres_d  = memres_q;
    bus_err_d = 1'b0;
`ifdef MISALIGN_TRAP_EN
    misalign_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        count_d = '0;
        if (req_valid) begin
          addr_d   = req_addr;
          we_d     = req_we;
          funct3_d = req_funct3;
          wdata_d  = req_wdata;
          state_d  = ACCESS;
`ifdef MISALIGN_TRAP_EN
          if (req_misaligned) begin
            state_d    = RESP;
            misalign_d = 1'b1;
            memres_d   = '0;
          end
`endif
        end
      end
      ACCESS: begin
        // Ack is tested first so it wins over a coincident timeout
        if (dmem_ack) begin
          if (!we_q) memres_d = load_fmt;
          state_d = RESP;
          count_d = '0;
        end else if (count_q == COUNT_LAST) begin
          state_d   = RESP;
          bus_err_d = 1'b1;
          memres_d  = '0;
          count_d   = '0;
        end else begin
          count_d = count_q + 8'd1;
        end
      end
      RESP: begin
        count_d = '0;
        state_d = IDLE;
      end
      default: begin
        count_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      funct3_q  <= '0;
      wdata_q   <= '0;
      memres_q  <= '0;
      bus_err_q <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      funct3_q  <= funct3_d;
      wdata_q   <= wdata_d;
      memres_q  <= memres_d;
      bus_err_q <= bus_err_d;
`ifdef MISALIGN_TRAP_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  // Reset gates stall so wb_we reads 1 while reset is held, even with req_valid high
  always_comb begin
    case (state_q)
      IDLE:    stall_c = req_valid & ~reset;
      ACCESS:  stall_c = 1'b1;
      default: stall_c = 1'b0;
    endcase
  end

  assign access     = (state_q == ACCESS);
  assign dmem_req   = access;
  assign dmem_we    = access & we_q;
  assign dmem_be    = access ? be_lat : '0;
  assign dmem_addr  = {addr_q[31:2], 2'b00};
  assign dmem_wdata = wdata_rep;
  assign stall      = stall_c;
  assign wb_we      = ~stall_c;
  assign memres_out = memres_q;
  assign bus_err    = bus_err_q;
`ifdef MISALIGN_TRAP_EN
  assign misalign   = misalign_q;
`else
  assign misalign   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: vector table of single-cycle-ack accesses plus hand sequences
// for late ack, timeout, reset in mid-access and misaligned accesses.
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        stall, wb_we;
  logic [31:0] memres_out;
  logic        bus_err, misalign;

  int n_cmp = 0;
  int n_err = 0;

  mem_stage_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .stall(stall), .wb_we(wb_we), .memres_out(memres_out),
    .bus_err(bus_err), .misalign(misalign)
  );

  always #5 clk = ~clk;

  // Running totals sampled on the falling edge; sequences take deltas.
  int          tot_req = 0, tot_stall = 0, tot_berr = 0, tot_mis = 0, tot_addr_chg = 0;
  logic        prev_req = 1'b0;
  logic [31:0] prev_addr = '0;
  always @(negedge clk) begin
    if (dmem_req) tot_req++;
    if (stall) tot_stall++;
    if (bus_err) tot_berr++;
    if (misalign) tot_mis++;
    if (dmem_req && prev_req && dmem_addr != prev_addr) tot_addr_chg++;
    prev_req  = dmem_req;
    prev_addr = dmem_addr;
  end

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic [31:0] dwdata;
    logic [31:0] daddr;
    logic [31:0] memres;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Called at posedge+1 with the DUT idle; returns at posedge+1 back in IDLE.
  task automatic apply(input vec_t v, input string tag);
    req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3;
    req_addr = v.addr; req_wdata = v.wdata; dmem_ack = 1'b0;
    #1;
    chk({tag, "_idle_stall"}, 32'(stall), 32'd1);
    chk({tag, "_idle_req"}, 32'(dmem_req), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_req"}, 32'(dmem_req), 32'd1);
    chk({tag, "_we"}, 32'(dmem_we), 32'(v.we));
    chk({tag, "_be"}, 32'(dmem_be), 32'(v.be));
    chk({tag, "_wdata"}, dmem_wdata, v.dwdata);
    chk({tag, "_addr"}, dmem_addr, v.daddr);
    chk({tag, "_acc_stall"}, 32'(stall), 32'd1);
    dmem_ack = 1'b1; dmem_rdata = v.rdata;
    @(posedge clk); #1;
    dmem_ack = 1'b0; dmem_rdata = '0;
    chk({tag, "_resp_stall"}, 32'(stall), 32'd0);
    chk({tag, "_resp_wbwe"}, 32'(wb_we), 32'd1);
    chk({tag, "_resp_req"}, 32'(dmem_req), 32'd0);
    chk({tag, "_memres"}, memres_out, v.memres);
    chk({tag, "_berr"}, 32'(bus_err), 32'd0);
    chk({tag, "_mis"}, 32'(misalign), 32'd0);
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_post_stall"}, 32'(stall), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s_req, s_stall, s_berr, s_mis, s_chg;
    logic seen;
    vec_t v;

    //            we    f3    addr          wdata         rdata         be       dwdata        daddr         memres
    vecs[0]  = '{1'b0, 3'd0, 32'h0000_0103, 32'h0,        32'h80FF_0000, 4'b1111, 32'h0,        32'h0000_0100, 32'hFFFF_FF80};
    vecs[1]  = '{1'b0, 3'd4, 32'h0000_0201, 32'h0,        32'h8A7F_C305, 4'b1111, 32'h0,        32'h0000_0200, 32'h0000_00C3};
    vecs[2]  = '{1'b0, 3'd0, 32'h0000_0201, 32'h0,        32'h8A7F_C305, 4'b1111, 32'h0,        32'h0000_0200, 32'hFFFF_FFC3};
    vecs[3]  = '{1'b0, 3'd0, 32'h0000_0202, 32'h0,        32'h8A7F_C305, 4'b1111, 32'h0,        32'h0000_0200, 32'h0000_007F};
    vecs[4]  = '{1'b0, 3'd1, 32'h0000_0302, 32'h0,        32'h8A7F_C305, 4'b1111, 32'h0,        32'h0000_0300, 32'hFFFF_8A7F};
    vecs[5]  = '{1'b0, 3'd5, 32'h0000_0300, 32'h0,        32'h8A7F_C305, 4'b1111, 32'h0,        32'h0000_0300, 32'h0000_C305};
    vecs[6]  = '{1'b0, 3'd1, 32'h0000_0300, 32'h0,        32'h8A7F_C305, 4'b1111, 32'h0,        32'h0000_0300, 32'hFFFF_C305};
    vecs[7]  = '{1'b0, 3'd5, 32'h0000_0302, 32'h0,        32'h8A7F_C305, 4'b1111, 32'h0,        32'h0000_0300, 32'h0000_8A7F};
    vecs[8]  = '{1'b0, 3'd2, 32'h0000_0404, 32'h0,        32'h8A7F_C305, 4'b1111, 32'h0,        32'h0000_0404, 32'h8A7F_C305};
    vecs[9]  = '{1'b0, 3'd3, 32'h0000_0408, 32'h0,        32'h1234_5678, 4'b1111, 32'h0,        32'h0000_0408, 32'h1234_5678};
    vecs[10] = '{1'b1, 3'd1, 32'h0000_0102, 32'h0000_BEEF, 32'hFFFF_FFFF, 4'b1100, 32'hBEEF_BEEF, 32'h0000_0100, 32'h1234_5678};
    vecs[11] = '{1'b1, 3'd0, 32'h0000_0003, 32'hAABB_CC5A, 32'hFFFF_FFFF, 4'b1000, 32'h5A5A_5A5A, 32'h0000_0000, 32'h1234_5678};
    vecs[12] = '{1'b1, 3'd0, 32'h0000_0001, 32'hAABB_CC5A, 32'hFFFF_FFFF, 4'b0010, 32'h5A5A_5A5A, 32'h0000_0000, 32'h1234_5678};
    vecs[13] = '{1'b1, 3'd1, 32'h0000_0000, 32'h1234_ABCD, 32'hFFFF_FFFF, 4'b0011, 32'hABCD_ABCD, 32'h0000_0000, 32'h1234_5678};
    vecs[14] = '{1'b1, 3'd2, 32'h0000_0010, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 4'b1111, 32'hDEAD_BEEF, 32'h0000_0010, 32'h1234_5678};
    vecs[15] = '{1'b1, 3'd5, 32'h0000_0020, 32'h0102_0304, 32'hFFFF_FFFF, 4'b1111, 32'h0102_0304, 32'h0000_0020, 32'h1234_5678};
    vecs[16] = '{1'b0, 3'd2, 32'h0000_0050, 32'h0,        32'hCAFE_F00D, 4'b1111, 32'h0,        32'h0000_0050, 32'hCAFE_F00D};

    // Reset state, with req_valid high to show stall is held low under reset
    reset = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2;
    req_addr = 32'h0000_0104; req_wdata = '0; dmem_ack = 1'b0; dmem_rdata = '0;
    #3;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_wbwe", 32'(wb_we), 32'd1);
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_dwe", 32'(dmem_we), 32'd0);
    chk("rst_be", 32'(dmem_be), 32'd0);
    chk("rst_addr", dmem_addr, 32'd0);
    chk("rst_memres", memres_out, 32'd0);
    chk("rst_berr", 32'(bus_err), 32'd0);
    chk("rst_mis", 32'(misalign), 32'd0);
    req_valid = 1'b0;
    #9 reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 17; i++) apply(vecs[i], $sformatf("v%0d", i));

    // LW acked on the 4th ACCESS cycle, which is also the timeout cycle: ack must win
    s_req = tot_req; s_stall = tot_stall; s_berr = tot_berr; s_chg = tot_addr_chg;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h0000_0600;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
    end
    dmem_ack = 1'b1; dmem_rdata = 32'h5566_7788;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    chk("late_wbwe", 32'(wb_we), 32'd1);
    chk("late_memres", memres_out, 32'h5566_7788);
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("late_req_cycles", 32'(tot_req - s_req), 32'd4);
    chk("late_stall_cycles", 32'(tot_stall - s_stall), 32'd5);
    chk("late_berr_count", 32'(tot_berr - s_berr), 32'd0);
    chk("late_addr_changes", 32'(tot_addr_chg - s_chg), 32'd0);

    // Reset in mid-ACCESS, then a clean restart
    s_berr = tot_berr; s_mis = tot_mis;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h0000_0900;
    @(posedge clk); #1;
    chk("mid_req_up", 32'(dmem_req), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("mid_rst_req", 32'(dmem_req), 32'd0);
    chk("mid_rst_stall", 32'(stall), 32'd0);
    chk("mid_rst_wbwe", 32'(wb_we), 32'd1);
    chk("mid_rst_memres", memres_out, 32'd0);
    req_valid = 1'b0;
    #2 reset = 1'b0;
    @(posedge clk); #1;
    v = '{1'b0, 3'd4, 32'h0000_0803, 32'h0, 32'hF100_0000, 4'b1111, 32'h0, 32'h0000_0800, 32'h0000_00F1};
    apply(v, "restart");
    chk("mid_rst_pulses", 32'((tot_berr - s_berr) + (tot_mis - s_mis)), 32'd0);

`ifdef MISALIGN_TRAP_EN
    s_req = tot_req; s_mis = tot_mis;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h0000_0101;
    #1;
    chk("mis_idle_stall", 32'(stall), 32'd1);
    @(posedge clk); #1;
    chk("mis_pulse", 32'(misalign), 32'd1);
    chk("mis_memres", memres_out, 32'd0);
    chk("mis_stall", 32'(stall), 32'd0);
    chk("mis_wbwe", 32'(wb_we), 32'd1);
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("mis_pulse_end", 32'(misalign), 32'd0);
    chk("mis_no_req", 32'(tot_req - s_req), 32'd0);
    chk("mis_pulse_count", 32'(tot_mis - s_mis), 32'd1);
`else
    s_mis = tot_mis;
    v = '{1'b0, 3'd2, 32'h0000_0101, 32'h0, 32'h1122_3344, 4'b1111, 32'h0, 32'h0000_0100, 32'h1122_3344};
    apply(v, "mis_lw");
    v = '{1'b0, 3'd1, 32'h0000_0301, 32'h0, 32'hAAAA_8001, 4'b1111, 32'h0, 32'h0000_0300, 32'hFFFF_8001};
    apply(v, "mis_lh");
    chk("mis_pulse_count", 32'(tot_mis - s_mis), 32'd0);
`endif

    // Timeout: no ack ever
    s_req = tot_req; s_stall = tot_stall; s_berr = tot_berr;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h0000_0700;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus_err) begin
        seen = 1'b1;
        break;
      end
    end
    chk("tmo_seen", 32'(seen), 32'd1);
    chk("tmo_memres", memres_out, 32'd0);
    chk("tmo_stall", 32'(stall), 32'd0);
    chk("tmo_wbwe", 32'(wb_we), 32'd1);
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("tmo_berr_end", 32'(bus_err), 32'd0);
    chk("tmo_req_cycles", 32'(tot_req - s_req), 32'd4);
    chk("tmo_stall_cycles", 32'(tot_stall - s_stall), 32'd5);
    chk("tmo_berr_count", 32'(tot_berr - s_berr), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
